// File: rtl/bmc_soft_pipe.sv
// bmc_soft_pipe: two-stage soft-decision branch-metric pipeline with frame beat tracking; define BMC_ERRCNT_EN to add per-frame error counts on frame_err
module bmc_soft_pipe #(
  parameter int SOFT_W = 3,
  parameter int FRAME_LEN = 8,
  parameter int ERR_THR = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*SOFT_W-1:0]   rx_sym,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SOFT_W:0]       bm00,
  output logic [SOFT_W:0]       bm01,
  output logic [SOFT_W:0]       bm10,
  output logic [SOFT_W:0]       bm11,
  output logic                  out_last,
  output logic [15:0]           frame_err
);
  localparam int W = SOFT_W + 1;
  localparam logic [SOFT_W-1:0] MAX = '1;
  logic en, v1, v2;
  logic [SOFT_W-1:0] s0, s1, s1_d0, s1_d1, s0_d0, s0_d1;
  logic [15:0] cnt;
  assign s0 = rx_sym[SOFT_W-1:0];
  assign s1 = rx_sym[2*SOFT_W-1:SOFT_W];
  assign en = !v2 || out_ready;
  assign in_ready = en;
  assign out_valid = v2;
  assign out_last = v2 && cnt == 16'(FRAME_LEN - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      s1_d0 <= '0;
      s1_d1 <= '0;
      s0_d0 <= '0;
      s0_d1 <= '0;
      bm00 <= '0;
      bm01 <= '0;
      bm10 <= '0;
      bm11 <= '0;
      cnt <= '0;
    end else begin
      if (en) begin
        v1 <= in_valid;
        v2 <= v1;
        s1_d0 <= s1;
        s1_d1 <= MAX - s1;
        s0_d0 <= s0;
        s0_d1 <= MAX - s0;
        bm00 <= W'(s1_d0) + W'(s0_d0);
        bm01 <= W'(s1_d0) + W'(s0_d1);
        bm10 <= W'(s1_d1) + W'(s0_d0);
        bm11 <= W'(s1_d1) + W'(s0_d1);
      end
      if (v2 && out_ready) cnt <= out_last ? '0 : cnt + 16'd1;
    end
  end
`ifdef BMC_ERRCNT_EN
  logic [W-1:0] m0, m1, mn;
  logic [15:0] run, run_nxt, fe;
  assign m0 = bm00 < bm01 ? bm00 : bm01;
  assign m1 = bm10 < bm11 ? bm10 : bm11;
  assign mn = m0 < m1 ? m0 : m1;
  assign run_nxt = (int'(mn) > ERR_THR && run != 16'hFFFF) ? run + 16'd1 : run;
  assign frame_err = fe;
  always_ff @(posedge clk) begin
    if (rst) begin
      run <= '0;
      fe <= '0;
    end else if (v2 && out_ready) begin
      run <= out_last ? '0 : run_nxt;
      if (out_last) fe <= run_nxt;
    end
  end
`else
  assign frame_err = '0;
`endif
endmodule
